// File: rtl/mesm6_mem_pkg.sv
// Shared types and sizes for the mesm6 memory subsystem: arbiter state encoding,
// bus widths and the mapped-address test.
package mesm6_mem_pkg;

  localparam int WORD_BITS = 48;
  localparam int ADDR_BITS = 15;

  typedef enum logic [2:0] {
    IDLE,
    D_ISSUE,
    D_WAIT,
    I_ISSUE,
    I_WAIT,
    RESP
  } arb_state_t;

  function automatic logic in_range(input logic [ADDR_BITS-1:0] addr, input int mem_words);
    return int'(addr) < mem_words;
  endfunction

endpackage

// File: rtl/mesm6_mem_port.sv
// Single-access RAM sequencer: one strobe cycle, then 1+WAIT_STATES wait cycles
// ending in a finish pulse that carries the captured read word.
module mesm6_mem_port
  import mesm6_mem_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_WORDS   = 32768
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 waiting,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [WORD_BITS-1:0] mem_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [WORD_BITS-1:0] mem_wdata,
  output logic                 finish,
  output logic                 capture,
  output logic [WORD_BITS-1:0] cap_data
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  logic [CNT_W-1:0] cnt;
  logic             mapped;

  assign mapped = in_range(addr, MEM_WORDS);

  // NOTE: state uses non-blocking assignments and the reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (waiting && !finish) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Unmapped accesses keep the full timing but never touch the RAM.
  always_comb begin
    mem_rd    = start && mapped && !we;
    mem_wr    = start && mapped && we;
    mem_addr  = (start && mapped) ? addr : '0;
    mem_wdata = (start && mapped && we) ? wdata : '0;
    finish    = waiting && (cnt == CNT_LAST);
    capture   = finish && !we;
    cap_data  = mapped ? mem_rdata : '0;
  end

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// Merges the mesm6 core's ibus and dbus onto one single-port RAM; dbus goes first,
// and both completions are reported together in a single RESP cycle.
module mesm6_mem_arbiter
  import mesm6_mem_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_WORDS   = 32768
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ibus_fetch,
  input  logic [ADDR_BITS-1:0] ibus_addr,
  output logic [WORD_BITS-1:0] ibus_input,
  output logic                 ibus_done,
  input  logic                 dbus_read,
  input  logic                 dbus_write,
  input  logic [ADDR_BITS-1:0] dbus_addr,
  input  logic [WORD_BITS-1:0] dbus_output,
  output logic [WORD_BITS-1:0] dbus_input,
  output logic                 dbus_done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [WORD_BITS-1:0] mem_wdata,
  input  logic [WORD_BITS-1:0] mem_rdata
);

  arb_state_t state, state_n;

  logic                 i_pend, d_pend, d_we;
  logic [ADDR_BITS-1:0] i_addr, d_addr;
  logic [WORD_BITS-1:0] d_wdata;

  logic                 d_phase, start, waiting, port_we;
  logic [ADDR_BITS-1:0] port_addr;
  logic                 finish, capture;
  logic [WORD_BITS-1:0] cap_data;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (dbus_read || dbus_write) state_n = D_ISSUE;
        else if (ibus_fetch)         state_n = I_ISSUE;
      end
      D_ISSUE: state_n = D_WAIT;
      D_WAIT:  if (finish) state_n = i_pend ? I_ISSUE : RESP;
      I_ISSUE: state_n = I_WAIT;
      I_WAIT:  if (finish) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    d_phase   = (state == D_ISSUE) || (state == D_WAIT);
    start     = (state == D_ISSUE) || (state == I_ISSUE);
    waiting   = (state == D_WAIT) || (state == I_WAIT);
    port_addr = d_phase ? d_addr : i_addr;
    port_we   = d_phase && d_we;
    ibus_done = (state == RESP) && i_pend;
    dbus_done = (state == RESP) && d_pend;
  end

  // Request fields are frozen on leaving IDLE; core-side changes are ignored until RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_pend  <= 1'b0;
      d_pend  <= 1'b0;
      d_we    <= 1'b0;
      i_addr  <= '0;
      d_addr  <= '0;
      d_wdata <= '0;
    end else if (state == IDLE) begin
      i_pend  <= ibus_fetch;
      d_pend  <= dbus_read || dbus_write;
      d_we    <= dbus_write;
      i_addr  <= ibus_addr;
      d_addr  <= dbus_addr;
      d_wdata <= dbus_output;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ibus_input <= '0;
      dbus_input <= '0;
    end else if (capture) begin
      if (d_phase) dbus_input <= cap_data;
      else         ibus_input <= cap_data;
    end
  end

  mesm6_mem_port #(
    .WAIT_STATES(WAIT_STATES),
    .MEM_WORDS  (MEM_WORDS)
  ) u_port (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .waiting  (waiting),
    .addr     (port_addr),
    .we       (port_we),
    .wdata    (d_wdata),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .finish   (finish),
    .capture  (capture),
    .cap_data (cap_data)
  );

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Directed bench for mesm6_mem_arbiter: three instances (W=0, W=2, W=1 with 1024 words),
// each backed by a behavioural RAM whose read data is valid only in its 1+W slot.
module tb_mesm6_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ibus_fetch [3];
  logic [14:0] ibus_addr  [3];
  logic [47:0] ibus_input [3];
  logic        ibus_done  [3];
  logic        dbus_read  [3];
  logic        dbus_write [3];
  logic [14:0] dbus_addr  [3];
  logic [47:0] dbus_output[3];
  logic [47:0] dbus_input [3];
  logic        dbus_done  [3];
  logic [14:0] mem_addr   [3];
  logic        mem_rd     [3];
  logic        mem_wr     [3];
  logic [47:0] mem_wdata  [3];
  logic [47:0] mem_rdata  [3];

  int total = 0;
  int bad   = 0;

  // Initial RAM contents as seen by the bench, before any write.
  function automatic logic [47:0] word_of(input logic [7:0] a);
    if (a == 8'd64) return 48'h1234_5678_9ABC;
    return {16'hA5A5, 8'h00, a, 8'h5A, ~a};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int W  = (k == 0) ? 0 : (k == 1) ? 2 : 1;
    localparam int MW = (k == 2) ? 1024 : 32768;

    mesm6_mem_arbiter #(.WAIT_STATES(W), .MEM_WORDS(MW)) dut (
      .clk        (clk),
      .reset      (reset),
      .ibus_fetch (ibus_fetch[k]),
      .ibus_addr  (ibus_addr[k]),
      .ibus_input (ibus_input[k]),
      .ibus_done  (ibus_done[k]),
      .dbus_read  (dbus_read[k]),
      .dbus_write (dbus_write[k]),
      .dbus_addr  (dbus_addr[k]),
      .dbus_output(dbus_output[k]),
      .dbus_input (dbus_input[k]),
      .dbus_done  (dbus_done[k]),
      .mem_addr   (mem_addr[k]),
      .mem_rd     (mem_rd[k]),
      .mem_wr     (mem_wr[k]),
      .mem_wdata  (mem_wdata[k]),
      .mem_rdata  (mem_rdata[k])
    );

    logic [47:0] ram     [256];
    logic        written [256];
    logic [W:0]  pv;
    logic [7:0]  pa [W+1];

    always @(posedge clk) begin
      if (!reset) begin
        for (int j = 0; j < 256; j++) written[j] <= 1'b0;
        pv <= '0;
      end else begin
        if (mem_wr[k]) begin
          ram[mem_addr[k][7:0]]     <= mem_wdata[k];
          written[mem_addr[k][7:0]] <= 1'b1;
        end
        for (int j = W; j > 0; j--) begin
          pv[j] <= pv[j-1];
          pa[j] <= pa[j-1];
        end
        pv[0] <= mem_rd[k];
        pa[0] <= mem_addr[k][7:0];
      end
    end

    assign mem_rdata[k] = pv[W] ? (written[pa[W]] ? ram[pa[W]] : word_of(pa[W]))
                                : 48'hBAD0_BAD0_BAD0;
  end

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ibus_fetch[k] = 0; ibus_addr[k] = '0; dbus_read[k] = 0; dbus_write[k] = 0;
      dbus_addr[k] = '0; dbus_output[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ibus_done[k], dbus_done[k], mem_rd[k], mem_wr[k], mem_addr[k], mem_wdata[k],
           ibus_input[k], dbus_input[k]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d got=%h %h %h want all zero", k,
                 mem_addr[k], ibus_input[k], dbus_input[k]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ibus_single();
    ibus_addr[0] = 15'o100; ibus_fetch[0] = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++; if (mem_rd[0] !== (c == 1)) begin bad++; $display("FAIL ib_rd c=%0d got=%b want=%b", c, mem_rd[0], c == 1); end
      total++; if (ibus_done[0] !== (c == 3)) begin bad++; $display("FAIL ib_done c=%0d got=%b want=%b", c, ibus_done[0], c == 3); end
      total++; if (dbus_done[0] !== 1'b0) begin bad++; $display("FAIL ib_dbus_done c=%0d got=%b want=0", c, dbus_done[0]); end
      if (c == 1) begin
        total++; if (mem_addr[0] !== 15'o100) begin bad++; $display("FAIL ib_addr got=%h want=%h", mem_addr[0], 15'o100); end
      end
      if (c == 3) begin
        total++; if (ibus_input[0] !== 48'h1234_5678_9ABC) begin bad++; $display("FAIL ib_data got=%h want=123456789abc", ibus_input[0]); end
        ibus_fetch[0] = 0;
      end
    end
  endtask

  task automatic test_dbus_write();
    dbus_addr[1] = 15'd5; dbus_output[1] = 48'hFFFF_0000_0001; dbus_write[1] = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      total++; if (mem_wr[1] !== (c == 1)) begin bad++; $display("FAIL wr_strobe c=%0d got=%b want=%b", c, mem_wr[1], c == 1); end
      total++; if (mem_rd[1] !== 1'b0) begin bad++; $display("FAIL wr_no_rd c=%0d got=%b want=0", c, mem_rd[1]); end
      total++; if (dbus_done[1] !== (c == 5)) begin bad++; $display("FAIL wr_done c=%0d got=%b want=%b", c, dbus_done[1], c == 5); end
      total++; if (ibus_done[1] !== 1'b0) begin bad++; $display("FAIL wr_ibus_done c=%0d got=%b want=0", c, ibus_done[1]); end
      if (c == 1) begin
        total++; if (mem_addr[1] !== 15'd5 || mem_wdata[1] !== 48'hFFFF_0000_0001) begin
          bad++; $display("FAIL wr_bus got addr=%h data=%h want addr=5 data=ffff00000001", mem_addr[1], mem_wdata[1]);
        end
      end
      if (c == 5) begin
        total++; if (dbus_input[1] !== 48'h0) begin bad++; $display("FAIL wr_dbus_input got=%h want=0", dbus_input[1]); end
        dbus_write[1] = 0;
      end
    end
    total++; if (g[1].ram[5] !== 48'hFFFF_0000_0001) begin bad++; $display("FAIL wr_ram got=%h want=ffff00000001", g[1].ram[5]); end
  endtask

  task automatic test_dual();
    dbus_addr[2] = 15'd7; dbus_read[2] = 1; ibus_addr[2] = 15'd8; ibus_fetch[2] = 1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      total++; if (mem_rd[2] !== (c == 1 || c == 4)) begin bad++; $display("FAIL dual_rd c=%0d got=%b want=%b", c, mem_rd[2], c == 1 || c == 4); end
      total++; if (dbus_done[2] !== (c == 7) || ibus_done[2] !== (c == 7)) begin
        bad++; $display("FAIL dual_done c=%0d got d=%b i=%b want both %b", c, dbus_done[2], ibus_done[2], c == 7);
      end
      if (c == 1) begin
        total++; if (mem_addr[2] !== 15'd7) begin bad++; $display("FAIL dual_addr_d got=%h want=7", mem_addr[2]); end
      end
      if (c == 4) begin
        total++; if (mem_addr[2] !== 15'd8) begin bad++; $display("FAIL dual_addr_i got=%h want=8", mem_addr[2]); end
      end
      if (c == 7) begin
        total++; if (dbus_input[2] !== word_of(8'd7)) begin bad++; $display("FAIL dual_ddata got=%h want=%h", dbus_input[2], word_of(8'd7)); end
        total++; if (ibus_input[2] !== word_of(8'd8)) begin bad++; $display("FAIL dual_idata got=%h want=%h", ibus_input[2], word_of(8'd8)); end
        dbus_read[2] = 0; ibus_fetch[2] = 0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    ibus_addr[0] = 15'd10; ibus_fetch[0] = 1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (ibus_done[0] === 1'b1) n_done++;
      total++; if (mem_rd[0] !== (c == 1 || c == 5)) begin bad++; $display("FAIL b2b_rd c=%0d got=%b want=%b", c, mem_rd[0], c == 1 || c == 5); end
      total++; if (ibus_done[0] !== (c == 3 || c == 7)) begin bad++; $display("FAIL b2b_done c=%0d got=%b want=%b", c, ibus_done[0], c == 3 || c == 7); end
      if (c == 5) begin
        total++; if (mem_addr[0] !== 15'd11) begin bad++; $display("FAIL b2b_addr2 got=%h want=b", mem_addr[0]); end
      end
      if (c == 3) begin
        total++; if (ibus_input[0] !== word_of(8'd10)) begin bad++; $display("FAIL b2b_data1 got=%h want=%h", ibus_input[0], word_of(8'd10)); end
        ibus_addr[0] = 15'd11;
      end
      if (c == 7) begin
        total++; if (ibus_input[0] !== word_of(8'd11)) begin bad++; $display("FAIL b2b_data2 got=%h want=%h", ibus_input[0], word_of(8'd11)); end
        ibus_fetch[0] = 0;
      end
    end
    total++; if (n_done != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", n_done); end
  endtask

  task automatic test_unmapped();
    dbus_addr[2] = 15'd2000; dbus_read[2] = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total++; if (mem_rd[2] !== 1'b0 || mem_wr[2] !== 1'b0) begin bad++; $display("FAIL unm_rd_strobe c=%0d got rd=%b wr=%b want 0", c, mem_rd[2], mem_wr[2]); end
      total++; if (dbus_done[2] !== (c == 4)) begin bad++; $display("FAIL unm_rd_done c=%0d got=%b want=%b", c, dbus_done[2], c == 4); end
      if (c == 4) begin
        total++; if (dbus_input[2] !== 48'h0) begin bad++; $display("FAIL unm_rd_data got=%h want=0", dbus_input[2]); end
        dbus_read[2] = 0;
      end
    end
    dbus_output[2] = 48'hDEAD_BEEF_CAFE; dbus_write[2] = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total++; if (mem_wr[2] !== 1'b0 || mem_rd[2] !== 1'b0) begin bad++; $display("FAIL unm_wr_strobe c=%0d got wr=%b rd=%b want 0", c, mem_wr[2], mem_rd[2]); end
      total++; if (dbus_done[2] !== (c == 4)) begin bad++; $display("FAIL unm_wr_done c=%0d got=%b want=%b", c, dbus_done[2], c == 4); end
      if (c == 4) dbus_write[2] = 0;
    end
  endtask

  task automatic test_reset_mid();
    dbus_addr[2] = 15'd3; dbus_read[2] = 1; ibus_addr[2] = 15'd4; ibus_fetch[2] = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0; dbus_read[2] = 0; ibus_fetch[2] = 0;
    @(negedge clk);
    total++;
    if ({ibus_done[2], dbus_done[2], mem_rd[2], mem_wr[2], mem_addr[2], mem_wdata[2],
         ibus_input[2], dbus_input[2]} !== '0) begin
      bad++; $display("FAIL midrst_outputs got addr=%h i=%h d=%h want all zero", mem_addr[2], ibus_input[2], dbus_input[2]);
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if ({ibus_done[2], dbus_done[2], mem_rd[2], mem_wr[2]} !== 4'b0) begin
        bad++; $display("FAIL midrst_quiet c=%0d got=%b want=0000", c, {ibus_done[2], dbus_done[2], mem_rd[2], mem_wr[2]});
      end
    end
    ibus_addr[2] = 15'd9; ibus_fetch[2] = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++; if (mem_rd[2] !== (c == 1)) begin bad++; $display("FAIL midrst_rd c=%0d got=%b want=%b", c, mem_rd[2], c == 1); end
      total++; if (ibus_done[2] !== (c == 4)) begin bad++; $display("FAIL midrst_done c=%0d got=%b want=%b", c, ibus_done[2], c == 4); end
      if (c == 4) begin
        total++; if (ibus_input[2] !== word_of(8'd9)) begin bad++; $display("FAIL midrst_data got=%h want=%h", ibus_input[2], word_of(8'd9)); end
        ibus_fetch[2] = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ibus_single();
    test_dbus_write();
    test_dual();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesm6_mem_arbiter.md
Name: mesm6_mem_arbiter

Overview:
- Sits directly downstream of mesm6_core. Merges the core's instruction bus (ibus) and data bus (dbus) onto one single-port synchronous 48-bit RAM with configurable wait states.
- Sequences simultaneous ibus+dbus requests and returns both completions in the same cycle. This matches the core's stall rule: the core advances only when every asserted request sees its done in one cycle.

Parameters:
- WAIT_STATES, 0, extra RAM cycles beyond the base 1-cycle read latency (0..15).
- MEM_WORDS, 32768, number of implemented words; higher addresses are unmapped.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- ibus_fetch  in  1  instruction fetch request, held until ibus_done
- ibus_addr  in  15  instruction word address
- ibus_input  out  48  instruction word returned
- ibus_done  out  1  one-cycle completion pulse for ibus
- dbus_read  in  1  data read request, held until dbus_done
- dbus_write  in  1  data write request, held until dbus_done
- dbus_addr  in  15  data word address
- dbus_output  in  48  write data from core
- dbus_input  out  48  read data returned
- dbus_done  out  1  one-cycle completion pulse for dbus
- mem_addr  out  15  RAM address
- mem_rd  out  1  RAM read strobe, one cycle per access
- mem_wr  out  1  RAM write strobe, one cycle per access
- mem_wdata  out  48  RAM write data
- mem_rdata  in  48  RAM read data, valid exactly 1+WAIT_STATES cycles after the mem_rd cycle

Behaviour:
- Reset (reset==0 at a clk edge):
  - State = IDLE; all outputs (dones, strobes, mem_addr, mem_wdata, ibus_input, dbus_input) = 0.
  - Pending flags cleared; wait counter = 0.
  - Reset mid-access abandons the access: no done, no strobe the following cycle.
- FSM states: IDLE, D_ISSUE, D_WAIT, I_ISSUE, I_WAIT, RESP.
- IDLE, sampling requests:
  - dbus_read|dbus_write -> D_ISSUE; latch i_pend=ibus_fetch and d_pend=1.
  - else ibus_fetch -> I_ISSUE; latch i_pend=1, d_pend=0.
  - else stay.
  - Address, write data and op type are latched here; later changes on the core inputs are ignored until RESP.
- D_ISSUE:
  - Drive mem_addr, and mem_wr (with mem_wdata) if write, else mem_rd, for exactly one cycle.
  - dbus_write has precedence if both dbus_read and dbus_write are asserted.
  - -> D_WAIT, counter = 0.
- D_WAIT:
  - Count to WAIT_STATES (i.e. 1+WAIT_STATES cycles after the issue cycle).
  - On the final cycle: capture mem_rdata into the dbus hold register (reads only). Writes leave dbus_input unchanged.
  - Then -> I_ISSUE if i_pend, else -> RESP.
- I_ISSUE / I_WAIT: same as D_ISSUE / D_WAIT using the latched ibus address, read only, capturing into the ibus hold register; then -> RESP.
- RESP (exactly one cycle):
  - ibus_done = i_pend; dbus_done = d_pend. Both pulse in the same cycle when both were requested.
  - ibus_input and dbus_input are registered and stable from the RESP cycle onward, until the next capture.
  - -> IDLE. A request seen in the cycle after RESP is a new transaction, even if the request line stayed high.
- Latency, request first sampled in IDLE at cycle 0:
  - Single access: strobe at cycle 1, capture at end of cycle 2+W, done at cycle 3+W. Writes use the same timing.
  - Dual access: done at cycle 5+2W.
- Unmapped address (>= MEM_WORDS): no strobe is issued; timing is unchanged; reads capture 0; writes are dropped.
- Priority: dbus is always serviced before ibus. There is no starvation, because every request completes within one RESP.
- A request withdrawn mid-access (protocol violation) still completes its RAM op and done pulse.
- Counter width = clog2(WAIT_STATES+1), minimum 1.

Decomposition:
- Package mesm6_mem_pkg holds:
  - state enum arb_state_t {IDLE, D_ISSUE, D_WAIT, I_ISSUE, I_WAIT, RESP};
  - WORD_BITS = 48 and ADDR_BITS = 15, shared with the core;
  - an in_range(addr) function against MEM_WORDS.
- One sub-module, mesm6_mem_port: the issue/wait/capture sequencer for a single access (start, addr, we, wdata -> strobes, rdata_q, finish). It is instantiated once and time-shared by the dbus and ibus phases under the top FSM.

Test Plan:
- W=0, ibus_fetch alone, addr 0o100, RAM[0o100]=0x123456789ABC -> mem_rd at cycle 1; ibus_done pulses at cycle 3 with ibus_input=0x123456789ABC; dbus_done stays 0.
- W=2, dbus_write addr 5, data 0xFFFF00000001 -> mem_wr one cycle at cycle 1 with mem_wdata matching; dbus_done at cycle 5; RAM[5] updated; dbus_input unchanged.
- W=1, dbus_read addr 7 and ibus_fetch addr 8 in the same cycle -> mem_rd addr 7 at cycle 1, mem_rd addr 8 at cycle 4; ibus_done and dbus_done both pulse at cycle 7 with the correct words.
- Back-to-back: ibus_fetch held high across two transactions with the address changed after the first done -> two separate RAM reads, two single-cycle done pulses, no merged or duplicated done.
- MEM_WORDS=1024, dbus_read addr 2000 -> no mem_rd; dbus_done at 3+W with dbus_input=0. Write to addr 2000 -> no mem_wr.
- reset driven low during D_WAIT of a dual request -> next cycle state IDLE, no done pulses, all strobes 0; a fresh request after release completes normally.
